// File: rtl/video_stream_out.sv
// video_stream_out: fixed raster timing generator fed from a small pixel FIFO, frame-aligned on in_sof.
// Optional `define VIDEO_STREAM_OUT_SKIP_EN flags zeroed active pixels on skip instead of plain black.
module video_stream_out #(
   parameter int unsigned H_TOTAL     = 740,
   parameter int unsigned V_TOTAL     = 500,
   parameter int unsigned HS_POS      = 50,
   parameter int unsigned VS_LINE     = 50,
   parameter int unsigned H_ACT_START = 100,
   parameter int unsigned H_ACT       = 400,
   parameter int unsigned V_ACT_START = 100,
   parameter int unsigned V_ACT       = 360,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic        rgb_clk,
   input  logic        reset,
   input  logic [23:0] in_rgb,
   input  logic        in_sof,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [23:0] rgb,
   output logic        de,
   output logic        skip,
   output logic        vs,
   output logic        hs,
   output logic        underflow,
   output logic        resync
);

   localparam int unsigned HW = $clog2(H_TOTAL);
   localparam int unsigned VW = $clog2(V_TOTAL);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   localparam logic [0:0] WAIT_SOF = 1'b0;
   localparam logic [0:0] RUN      = 1'b1;

   // ---------------- raster counters ----------------
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic [31:0]   h_ext;
   logic [31:0]   v_ext;
   logic          h_wrap;
   logic          v_wrap;

   assign h_ext  = 32'(hcount);
   assign v_ext  = 32'(vcount);
   assign h_wrap = (h_ext == H_TOTAL - 1);
   assign v_wrap = (v_ext == V_TOTAL - 1);

   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (h_wrap) begin
         hcount <= '0;
         if (v_wrap)
            vcount <= '0;
         else
            vcount <= vcount + VW'(1);
      end else begin
         hcount <= hcount + HW'(1);
      end
   end

   logic hs_r;
   logic vs_r;
   logic act;
   logic pre_first;
   logic first_pix;

   assign hs_r = (h_ext == HS_POS);
   assign vs_r = (v_ext == VS_LINE) && (hcount == '0);
   assign act  = (h_ext >= H_ACT_START) && (h_ext < H_ACT_START + H_ACT) &&
                 (v_ext >= V_ACT_START) && (v_ext < V_ACT_START + V_ACT);
   assign pre_first = (h_ext == H_ACT_START - 1) && (v_ext == V_ACT_START);
   assign first_pix = (h_ext == H_ACT_START) && (v_ext == V_ACT_START);

   // ---------------- pixel FIFO {sof, rgb} ----------------
   logic [24:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [24:0] head;
   logic        head_sof;
   logic [23:0] head_rgb;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = ~full;
   assign push     = in_valid && ~full;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign head_sof = head[24];
   assign head_rgb = head[23:0];

   always_ff @(posedge rgb_clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {in_sof, in_rgb};
   end

   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // ---------------- alignment FSM ----------------
   logic [0:0] state;
   logic [0:0] state_d;
   logic       emit;
   logic       uf_set;
   logic       rs_set;

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      emit    = 1'b0;
      uf_set  = 1'b0;
      rs_set  = 1'b0;
      case (state)
         WAIT_SOF: begin
            // Non-sof entries are flushed; a sof entry is held until the next frame start.
            if (!empty && !head_sof)
               pop = 1'b1;
            if (pre_first && !empty && head_sof)
               state_d = RUN;
         end
         RUN: begin
            if (act) begin
               if (empty) begin
                  uf_set  = 1'b1;
                  state_d = WAIT_SOF;
               end else if (head_sof && !first_pix) begin
                  // Leave the early sof at the head so it aligns the next frame.
                  rs_set  = 1'b1;
                  state_d = WAIT_SOF;
               end else begin
                  pop  = 1'b1;
                  emit = 1'b1;
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase
   end

`ifdef VIDEO_STREAM_OUT_SKIP_EN
   logic skip_d;
   assign skip_d = act && !emit;
`else
   logic skip_d;
   assign skip_d = 1'b0;
`endif

   always_ff @(posedge rgb_clk or posedge reset) begin
      if (reset) begin
         state     <= WAIT_SOF;
         rgb       <= '0;
         de        <= 1'b0;
         skip      <= 1'b0;
         vs        <= 1'b0;
         hs        <= 1'b0;
         underflow <= 1'b0;
         resync    <= 1'b0;
      end else begin
         state     <= state_d;
         rgb       <= emit ? head_rgb : '0;
         de        <= act;
         skip      <= skip_d;
         vs        <= vs_r;
         hs        <= hs_r;
         underflow <= underflow | uf_set;
         resync    <= resync | rs_set;
      end
   end

endmodule

// File: tb/tb_video_stream_out.sv
// Self-checking bench for video_stream_out using reduced raster timing and a pixel scoreboard.
// Build with +define+VIDEO_STREAM_OUT_SKIP_EN to exercise the skip variant.
module tb_video_stream_out;

   localparam int unsigned H_TOTAL     = 48;
   localparam int unsigned V_TOTAL     = 20;
   localparam int unsigned HS_POS      = 3;
   localparam int unsigned VS_LINE     = 2;
   localparam int unsigned H_ACT_START = 8;
   localparam int unsigned H_ACT       = 32;
   localparam int unsigned V_ACT_START = 4;
   localparam int unsigned V_ACT       = 8;
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned FT          = H_TOTAL * V_TOTAL;
   localparam int unsigned NPIX        = H_ACT * V_ACT;
`ifdef VIDEO_STREAM_OUT_SKIP_EN
   localparam logic SK = 1'b1;
`else
   localparam logic SK = 1'b0;
`endif

   logic        rgb_clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_rgb;
   logic        in_sof;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] rgb;
   logic        de;
   logic        skip;
   logic        vs;
   logic        hs;
   logic        underflow;
   logic        resync;

   int tests_run = 0;
   int failures = 0;
   int cyc;
   logic [24:0] src_q[$];
   logic [24:0] exp_q[$];
   int   src_idx;
   logic acc;
   int   hold_until = 0;
   int   stall_from = 1000000;
   int   stall_len = 0;

   video_stream_out #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HS_POS(HS_POS), .VS_LINE(VS_LINE),
      .H_ACT_START(H_ACT_START), .H_ACT(H_ACT), .V_ACT_START(V_ACT_START),
      .V_ACT(V_ACT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .rgb_clk(rgb_clk), .reset(reset), .in_rgb(in_rgb), .in_sof(in_sof),
      .in_valid(in_valid), .in_ready(in_ready), .rgb(rgb), .de(de), .skip(skip),
      .vs(vs), .hs(hs), .underflow(underflow), .resync(resync)
   );

   always #5 rgb_clk = ~rgb_clk;

   // cyc mirrors the raster position the DUT counters hold during the current cycle
   always @(posedge rgb_clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic logic [23:0] pix(input int f, input int i);
      return {8'(f + 1), 16'(i * 5 + 3)};
   endfunction

   // source driver: presents src_q entries in order, honouring hold and stall windows
   initial begin
      in_valid = 1'b0; in_sof = 1'b0; in_rgb = '0; src_idx = 0; acc = 1'b0;
      forever begin
         @(negedge rgb_clk);
         if (reset) begin
            src_idx = 0;
            acc = 1'b0;
         end else if (acc) begin
            src_idx++;
         end
         if (!reset && src_idx < src_q.size() && cyc >= hold_until &&
             !(cyc >= stall_from && cyc < stall_from + stall_len)) begin
            in_valid = 1'b1;
            {in_sof, in_rgb} = src_q[src_idx];
         end else begin
            in_valid = 1'b0;
            in_sof = 1'b0;
            in_rgb = '0;
         end
         acc = in_valid && in_ready;
      end
   end

   task automatic apply_reset();
      @(posedge rgb_clk);
      #2 reset = 1'b1;
      src_q.delete();
      exp_q.delete();
      hold_until = 0;
      stall_from = 1000000;
      stall_len = 0;
      repeat (3) @(posedge rgb_clk);
      #2 reset = 1'b0;
      @(posedge rgb_clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge rgb_clk);
      #2;
      tests_run++; if (rgb !== 24'h0)      begin failures++; $display("FAIL reset_rgb: got %h, expected 000000", rgb); end
      tests_run++; if (de !== 1'b0)        begin failures++; $display("FAIL reset_de: got %b, expected 0", de); end
      tests_run++; if (skip !== 1'b0)      begin failures++; $display("FAIL reset_skip: got %b, expected 0", skip); end
      tests_run++; if (vs !== 1'b0)        begin failures++; $display("FAIL reset_vs: got %b, expected 0", vs); end
      tests_run++; if (hs !== 1'b0)        begin failures++; $display("FAIL reset_hs: got %b, expected 0", hs); end
      tests_run++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %b, expected 0", underflow); end
      tests_run++; if (resync !== 1'b0)    begin failures++; $display("FAIL reset_resync: got %b, expected 0", resync); end
      tests_run++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_idle_timing();
      int unsigned t, h, v;
      int hs_cnt, vs_cnt, de_cnt;
      logic ehs, evs, ede;
      logic [29:0] got, want;
      hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
      apply_reset();
      while (cyc < FT) begin
         @(negedge rgb_clk);
         t = (cyc - 1) % FT;
         h = t % H_TOTAL;
         v = t / H_TOTAL;
         ehs = (h == HS_POS);
         evs = (v == VS_LINE) && (h == 0);
         ede = (h >= H_ACT_START) && (h < H_ACT_START + H_ACT) &&
               (v >= V_ACT_START) && (v < V_ACT_START + V_ACT);
         want = {ehs, evs, ede, ede & SK, 1'b0, 1'b0, 24'h0};
         got  = {hs, vs, de, skip, underflow, resync, rgb};
         tests_run++;
         if (got !== want) begin
            failures++;
            $display("FAIL idle_timing t=%0d: got {hs,vs,de,skip,uf,rs,rgb}=%h, expected %h", t, got, want);
         end
         hs_cnt += int'(hs);
         vs_cnt += int'(vs);
         de_cnt += int'(de);
      end
      tests_run++; if (hs_cnt != V_TOTAL) begin failures++; $display("FAIL idle_hs_count: got %0d, expected %0d", hs_cnt, V_TOTAL); end
      tests_run++; if (vs_cnt != 1)       begin failures++; $display("FAIL idle_vs_count: got %0d, expected 1", vs_cnt); end
      tests_run++; if (de_cnt != NPIX)    begin failures++; $display("FAIL idle_de_count: got %0d, expected %0d", de_cnt, NPIX); end
   endtask

   task automatic test_stream();
      logic [24:0] e;
      int first_de, bad_blank;
      first_de = -1; bad_blank = 0;
      apply_reset();
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < int'(NPIX); i++) begin
            src_q.push_back({i == 0, pix(f, i)});
            exp_q.push_back({1'b0, pix(f, i)});
         end
      while (cyc < 2 * FT) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            if (first_de < 0) first_de = cyc - 1;
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL stream_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL stream_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end else if (rgb !== 24'h0) bad_blank++;
      end
      tests_run++; if (first_de != int'(V_ACT_START * H_TOTAL + H_ACT_START)) begin failures++; $display("FAIL stream_latency: first de at t=%0d, expected %0d", first_de, V_ACT_START * H_TOTAL + H_ACT_START); end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_missing: %0d pixels not output, expected 0", exp_q.size()); end
      tests_run++; if (bad_blank != 0) begin failures++; $display("FAIL stream_blank_rgb: got %0d nonzero blank cycles, expected 0", bad_blank); end
      tests_run++; if ({underflow, resync} !== 2'b00) begin failures++; $display("FAIL stream_flags: got uf,rs=%b, expected 00", {underflow, resync}); end
   endtask

   task automatic test_discard();
      logic [24:0] e;
      apply_reset();
      for (int k = 0; k < 10; k++) src_q.push_back({1'b0, 24'hC0FF00 + 24'(k)});
      for (int i = 0; i < int'(NPIX); i++) begin
         src_q.push_back({i == 0, pix(2, i)});
         exp_q.push_back({1'b0, pix(2, i)});
      end
      while (cyc < FT) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL discard_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL discard_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end
      end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL discard_missing: %0d pixels not output, expected 0", exp_q.size()); end
      tests_run++; if ({underflow, resync} !== 2'b00) begin failures++; $display("FAIL discard_flags: got uf,rs=%b, expected 00", {underflow, resync}); end
   endtask

   task automatic test_underflow();
      logic [24:0] e;
      apply_reset();
      stall_from = int'((V_ACT_START + 1) * H_TOTAL + H_ACT_START + 4);
      stall_len  = 20;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < int'(NPIX); i++) src_q.push_back({i == 0, pix(f, i)});
      // 16-deep FIFO drains 15 pixels after the stall starts at pixel 4 of line 1
      for (int i = 0; i < 51; i++) exp_q.push_back({1'b0, pix(0, i)});
      for (int i = 51; i < int'(NPIX); i++) exp_q.push_back({SK, 24'h0});
      for (int i = 0; i < int'(NPIX); i++) exp_q.push_back({1'b0, pix(1, i)});
      while (cyc < 2 * FT) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL underflow_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL underflow_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end
      end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL underflow_missing: %0d pixels not output, expected 0", exp_q.size()); end
      tests_run++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag: got %b, expected 1", underflow); end
      tests_run++; if (resync !== 1'b0)    begin failures++; $display("FAIL underflow_resync: got %b, expected 0", resync); end
   endtask

   task automatic test_resync();
      logic [24:0] e;
      int inj;
      inj = 5 * int'(H_ACT) + 20;
      apply_reset();
      for (int i = 0; i < inj; i++) begin
         src_q.push_back({i == 0, pix(0, i)});
         exp_q.push_back({1'b0, pix(0, i)});
      end
      for (int i = inj; i < int'(NPIX); i++) exp_q.push_back({SK, 24'h0});
      for (int i = 0; i < int'(NPIX); i++) begin
         src_q.push_back({i == 0, pix(3, i)});
         exp_q.push_back({1'b0, pix(3, i)});
      end
      while (cyc < 2 * FT) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL resync_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL resync_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end
      end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL resync_missing: %0d pixels not output, expected 0", exp_q.size()); end
      tests_run++; if (resync !== 1'b1)    begin failures++; $display("FAIL resync_flag: got %b, expected 1", resync); end
      tests_run++; if (underflow !== 1'b0) begin failures++; $display("FAIL resync_underflow: got %b, expected 0", underflow); end
   endtask

   task automatic test_mid_reset();
      logic [24:0] e;
      int stop;
      stop = int'((V_ACT_START + 2) * H_TOTAL + H_ACT_START + 12);
      apply_reset();
      hold_until = int'(5 * H_TOTAL);
      for (int i = 0; i < 12; i++) src_q.push_back({i == 0, pix(4, i)});
      for (int i = 0; i < int'(2 * H_ACT + 12); i++) exp_q.push_back({SK, 24'h0});
      while (cyc < stop) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL midrst_pre_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL midrst_pre_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end
      end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_pre_missing: %0d pixels not output, expected 0", exp_q.size()); end
      @(posedge rgb_clk);
      #2 reset = 1'b1;
      src_q.delete();
      #1;
      tests_run++; if ({rgb, de, skip, vs, hs, underflow, resync} !== 30'h0) begin failures++; $display("FAIL midrst_outputs: got %h, expected 0", {rgb, de, skip, vs, hs, underflow, resync}); end
      tests_run++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b, expected 1", in_ready); end
      apply_reset();
      // a FIFO that survived reset would realign on its held sof and emit data
      for (int i = 0; i < int'(NPIX); i++) exp_q.push_back({SK, 24'h0});
      while (cyc < FT) begin
         @(negedge rgb_clk);
         if (de === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL midrst_post_extra: de at t=%0d, expected no more pixels", cyc - 1);
            end else begin
               e = exp_q.pop_front();
               if ({skip, rgb} !== e) begin failures++; $display("FAIL midrst_post_pixel t=%0d: got %h, expected %h", cyc - 1, {skip, rgb}, e); end
            end
         end
      end
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_post_missing: %0d pixels not output, expected 0", exp_q.size()); end
      tests_run++; if ({underflow, resync} !== 2'b00) begin failures++; $display("FAIL midrst_flags: got uf,rs=%b, expected 00", {underflow, resync}); end
   endtask

   initial begin
      test_reset();
      test_idle_timing();
      test_stream();
      test_discard();
      test_underflow();
      test_resync();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
